decrementer: RTL and testbench

DECREMENTER -- requirements
Module: decrementer

---
 rtl/decrementer.sv | 82 ++++++++
 tb/tb_decrementer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/decrementer.sv
// Loadable down-counter with an IDLE/RUN/DONE FSM and a sticky underflow flag.
// Underflow either holds at zero or wraps to all-ones, selected by SATURATE.
module decrementer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SATURATE = 1
) (
    input  logic             aclk,
    input  logic             srst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             busy,
    output logic             underflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             uflow_q, uflow_d;

    // State and datapath registers; srst overrides every other input.
    always_ff @(posedge aclk) begin
        if (srst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            uflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            uflow_q <= uflow_d;
        end
    end

    // Next state: clr > load > dec, one action per cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        uflow_d = uflow_q;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            uflow_d = 1'b0;
        end else if (load) begin
            cnt_d   = load_val;
            uflow_d = 1'b0;
            state_d = (load_val != '0) ? RUN : DONE;
        end else if (dec) begin
            case (state_q)
                RUN: begin
                    cnt_d = cnt_q - WIDTH'(1);
                    if (cnt_q == WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    uflow_d = 1'b1;
                    if (SATURATE == 0) begin
                        cnt_d   = '1;
                        state_d = RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode registers only; no input reaches an output combinationally.
    assign out       = cnt_q;
    assign zero      = (cnt_q == '0);
    assign busy      = (state_q == RUN);
    assign underflow = uflow_q;

endmodule

// File: tb/tb_decrementer.sv
// Scoreboard bench: a saturating and a wrapping decrementer share stimulus;
// each cycle's hand-computed expectations are queued and checked by a monitor.
module tb_decrementer;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] o_s;
        logic         b_s;
        logic         u_s;
        logic [W-1:0] o_w;
        logic         b_w;
        logic         u_w;
        string        tag;
    } exp_t;

    logic         aclk = 1'b0;
    logic         srst, clr, load, dec;
    logic [W-1:0] load_val;
    logic [W-1:0] out_s, out_w;
    logic         zero_s, zero_w, busy_s, busy_w, uf_s, uf_w;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   stim_done = 1'b0;

    always #5 aclk = ~aclk;

    decrementer #(.WIDTH(W), .SATURATE(1)) dut_sat (
        .aclk(aclk), .srst(srst), .clr(clr), .load(load), .load_val(load_val),
        .dec(dec), .out(out_s), .zero(zero_s), .busy(busy_s), .underflow(uf_s)
    );

    decrementer #(.WIDTH(W), .SATURATE(0)) dut_wrap (
        .aclk(aclk), .srst(srst), .clr(clr), .load(load), .load_val(load_val),
        .dec(dec), .out(out_w), .zero(zero_w), .busy(busy_w), .underflow(uf_w)
    );

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after that edge.
    task automatic cyc(input logic s, input logic c, input logic l, input logic [W-1:0] lv,
                       input logic d, input logic [W-1:0] eo_s, input logic eb_s,
                       input logic eu_s, input logic [W-1:0] eo_w, input logic eb_w,
                       input logic eu_w, input string tag);
        exp_t e;
        @(negedge aclk);
        srst = s; clr = c; load = l; load_val = lv; dec = d;
        e.o_s = eo_s; e.b_s = eb_s; e.u_s = eu_s;
        e.o_w = eo_w; e.b_w = eb_w; e.u_w = eu_w;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: every edge presents a result; pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge aclk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.tag, " sat.out"},   int'(out_s),  int'(e.o_s));
                chk({e.tag, " sat.zero"},  int'(zero_s), int'(e.o_s == '0));
                chk({e.tag, " sat.busy"},  int'(busy_s), int'(e.b_s));
                chk({e.tag, " sat.uf"},    int'(uf_s),   int'(e.u_s));
                chk({e.tag, " wrap.out"},  int'(out_w),  int'(e.o_w));
                chk({e.tag, " wrap.zero"}, int'(zero_w), int'(e.o_w == '0));
                chk({e.tag, " wrap.busy"}, int'(busy_w), int'(e.b_w));
                chk({e.tag, " wrap.uf"},   int'(uf_w),   int'(e.u_w));
            end
        end
    end

    initial begin
        srst = 1'b1; clr = 1'b0; load = 1'b0; dec = 1'b0; load_val = '0;

        for (int i = 0; i < 5; i++)
            cyc(1, 0, 0, 8'd0, 0, 8'd0, 0, 0, 8'd0, 0, 0, "reset");
        cyc(0, 0, 0, 8'd0, 1, 8'd0, 0, 0, 8'd0, 0, 0, "dec_idle");

        cyc(0, 0, 1, 8'd3, 0, 8'd3, 1, 0, 8'd3, 1, 0, "load3");
        cyc(0, 0, 0, 8'd0, 1, 8'd2, 1, 0, 8'd2, 1, 0, "dec_a");
        cyc(0, 0, 0, 8'd0, 1, 8'd1, 1, 0, 8'd1, 1, 0, "dec_b");
        cyc(0, 0, 0, 8'd0, 1, 8'd0, 0, 0, 8'd0, 0, 0, "dec_to0");

        cyc(0, 0, 0, 8'd0, 1, 8'd0, 0, 1, 8'd255, 1, 1, "under1");
        cyc(0, 0, 0, 8'd0, 1, 8'd0, 0, 1, 8'd254, 1, 1, "under2");
        cyc(0, 0, 1, 8'd5, 0, 8'd5, 1, 0, 8'd5, 1, 0, "load5");

        cyc(0, 0, 1, 8'd10, 1, 8'd10, 1, 0, 8'd10, 1, 0, "load_dec");
        cyc(0, 1, 1, 8'd7, 0, 8'd0, 0, 0, 8'd0, 0, 0, "clr_load");
        cyc(0, 0, 0, 8'd0, 1, 8'd0, 0, 0, 8'd0, 0, 0, "idle_after_clr");

        cyc(0, 0, 1, 8'd0, 0, 8'd0, 0, 0, 8'd0, 0, 0, "load0");
        cyc(0, 0, 0, 8'd0, 1, 8'd0, 0, 1, 8'd255, 1, 1, "load0_dec");
        cyc(0, 1, 0, 8'd0, 1, 8'd0, 0, 0, 8'd0, 0, 0, "clr_dec");

        cyc(0, 0, 1, 8'd200, 0, 8'd200, 1, 0, 8'd200, 1, 0, "load200");
        for (int i = 1; i <= 50; i++)
            cyc(0, 0, 0, 8'd0, 1, 8'(200 - i), 1, 0, 8'(200 - i), 1, 0, "b2b_dec");
        cyc(1, 0, 1, 8'd9, 1, 8'd0, 0, 0, 8'd0, 0, 0, "srst_mid");
        cyc(0, 0, 0, 8'd0, 1, 8'd0, 0, 0, 8'd0, 0, 0, "post_srst_dec");
        cyc(0, 0, 1, 8'd1, 0, 8'd1, 1, 0, 8'd1, 1, 0, "post_srst_load");
        cyc(0, 0, 0, 8'd0, 1, 8'd0, 0, 0, 8'd0, 0, 0, "one_to0");
        cyc(0, 0, 0, 8'd0, 0, 8'd0, 0, 0, 8'd0, 0, 0, "hold");

        // Allow the monitor to drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge aclk);
        @(posedge aclk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #100000;
        if (!stim_done) begin
            $display("FAIL watchdog: timeout reached, expected completion");
            $fatal(1, "watchdog");
        end
    end

endmodule
